// File: rtl/irig_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : irig_bit_decoder
// Purpose  : IRIG-B DC-level front end. Synchronizes the raw input, measures
//            every high pulse, classifies it as zero / one / position marker /
//            error, finds frame sync on the P0-Pr double marker and tracks
//            the bit index inside the 100-bit frame.
// Ports    : clk        in   system clock
//            hrd_rst    in   asynchronous active-high reset
//            irig_in    in   raw IRIG-B level (asynchronous to clk)
//            irig_data  out  last symbol: 001 zero, 011 one, 111 marker,
//                            000 error; held until the next symbol
//            en         out  one-cycle strobe, irig_data/ind freshly valid
//            ind        out  bit index 0..99 (0 while unlocked)
//            cal        out  frame lock
//            sym_err    out  one-cycle pulse on error symbol, misplaced
//                            marker or loss of signal
// Revision : 1.0 - initial release
// ============================================================================
module irig_bit_decoder #(
  parameter int CNT_W      = 16,
  parameter int ZERO_MIN   = 1500,
  parameter int ONE_MIN    = 3500,
  parameter int MARK_MIN   = 6500,
  parameter int MARK_MAX   = 9500,
  parameter int PERIOD_MAX = 12000
) (
  input  logic       clk,
  input  logic       hrd_rst,
  input  logic       irig_in,
  output logic [2:0] irig_data,
  output logic       en,
  output logic [7:0] ind,
  output logic       cal,
  output logic       sym_err
);

  localparam logic [2:0]       c_SYM_ERR   = 3'b000;
  localparam logic [2:0]       c_SYM_ZERO  = 3'b001;
  localparam logic [2:0]       c_SYM_ONE   = 3'b011;
  localparam logic [2:0]       c_SYM_MARK  = 3'b111;
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_ZERO_MIN  = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] c_ONE_MIN   = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] c_MARK_MIN  = CNT_W'(MARK_MIN);
  localparam logic [CNT_W-1:0] c_MARK_MAX  = CNT_W'(MARK_MAX);
  localparam logic [CNT_W-1:0] c_PER_LAST  = CNT_W'(PERIOD_MAX - 1);
  localparam logic [7:0]       c_IND_LAST  = 8'd99;
  localparam logic [3:0]       c_UNIT_LAST = 4'd9;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    ARMED  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning and pulse measurement
  // --------------------------------------------------------------------------
  logic             sync1_q, sync2_q, dly_q;
  logic [2:0]       prime_q;
  logic             pulse_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] period_q;
  logic             fall_q;
  logic [2:0]       sym_q;

  logic             primed;
  logic             rise;
  logic             fall;
  logic             timeout;
  logic [2:0]       sym_class;

  // Edges are ignored until the synchronizer and delay stage all hold real
  // samples again after reset; otherwise an input that is high while reset
  // releases would look like a rising edge and produce a partial symbol.
  assign primed  = prime_q[2];
  assign rise    = primed & sync2_q & ~dly_q;
  // A fall only counts when its rise was seen, so a pulse cut by reset is
  // never reported.
  assign fall    = primed & ~sync2_q & dly_q & pulse_q;
  // Fires on the single transition into PERIOD_MAX; a coincident rising
  // edge restarts the period instead.
  assign timeout = (period_q == c_PER_LAST) & ~rise;

  always_comb begin
    sym_class = c_SYM_ERR;
    if (width_q < c_ZERO_MIN) begin
      sym_class = c_SYM_ERR;
    end else if (width_q < c_ONE_MIN) begin
      sym_class = c_SYM_ZERO;
    end else if (width_q < c_MARK_MIN) begin
      sym_class = c_SYM_ONE;
    end else if (width_q <= c_MARK_MAX) begin
      sym_class = c_SYM_MARK;
    end else begin
      sym_class = c_SYM_ERR;
    end
  end

  always_ff @(posedge clk or posedge hrd_rst) begin
    if (hrd_rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      prime_q  <= '0;
      pulse_q  <= 1'b0;
      width_q  <= '0;
      period_q <= '0;
      fall_q   <= 1'b0;
      sym_q    <= c_SYM_ERR;
    end else begin
      sync1_q <= irig_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      prime_q <= {prime_q[1:0], 1'b1};

      if (rise) begin
        pulse_q <= 1'b1;
      end else if (fall) begin
        pulse_q <= 1'b0;
      end

      if (rise) begin
        width_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (sync2_q && (width_q != c_CNT_MAX)) begin
        width_q <= width_q + 1'b1;
      end

      if (rise) begin
        period_q <= '0;
      end else if (period_q != c_CNT_MAX) begin
        period_q <= period_q + 1'b1;
      end

      fall_q <= fall;
      if (fall) begin
        sym_q <= sym_class;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame sync FSM and output registers
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] data_q,  data_d;
  logic       en_q,    en_d;
  logic [7:0] ind_q,   ind_d;
  logic [3:0] unit_q,  unit_d;   // ones digit of ind_q, avoids a modulo
  logic       cal_q,   cal_d;
  logic       err_q,   err_d;

  logic [7:0] ind_nxt;
  logic [3:0] unit_nxt;
  logic       mark_exp;
  logic       is_mark;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    en_d     = 1'b0;
    ind_d    = ind_q;
    unit_d   = unit_q;
    cal_d    = cal_q;
    err_d    = 1'b0;

    ind_nxt  = (ind_q == c_IND_LAST) ? 8'd0 : ind_q + 8'd1;
    unit_nxt = ((ind_q == c_IND_LAST) || (unit_q == c_UNIT_LAST)) ? 4'd0
                                                                  : unit_q + 4'd1;
    // Markers sit at 0 and at every index ending in 9.
    mark_exp = (ind_nxt == 8'd0) || (unit_nxt == c_UNIT_LAST);
    is_mark  = (sym_q == c_SYM_MARK);

    // Outside LOCKED the index reads 0; this also clears the index of a
    // faulting symbol one cycle after it was presented.
    if (state_q != LOCKED) begin
      ind_d  = 8'd0;
      unit_d = 4'd0;
    end

    if (timeout) begin
      // Loss of signal outranks a symbol finishing in the same cycle: any
      // pulse that long is out of range anyway.
      state_d = HUNT;
      ind_d   = 8'd0;
      unit_d  = 4'd0;
      cal_d   = 1'b0;
      err_d   = 1'b1;
    end else if (fall_q) begin
      en_d   = 1'b1;
      data_d = sym_q;
      if (sym_q == c_SYM_ERR) begin
        err_d = 1'b1;
      end
      case (state_q)
        HUNT: begin
          if (is_mark) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (is_mark) begin
            state_d = LOCKED;   // Pr: index stays 0
            cal_d   = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          ind_d  = ind_nxt;
          unit_d = unit_nxt;
          if ((sym_q == c_SYM_ERR) || (is_mark != mark_exp)) begin
            state_d = HUNT;
            cal_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          cal_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge hrd_rst) begin
    if (hrd_rst) begin
      state_q <= HUNT;
      data_q  <= c_SYM_ERR;
      en_q    <= 1'b0;
      ind_q   <= 8'd0;
      unit_q  <= 4'd0;
      cal_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ind_q   <= ind_d;
      unit_q  <= unit_d;
      cal_q   <= cal_d;
      err_q   <= err_d;
    end
  end

  assign irig_data = data_q;
  assign en        = en_q;
  assign ind       = ind_q;
  assign cal       = cal_q;
  assign sym_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_irig_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_irig_bit_decoder
// Purpose  : Directed self-checking bench for irig_bit_decoder. Timing
//            parameters are scaled by 1/100 (pulse period 100 clk) so a
//            full frame stays short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irig_bit_decoder;

  localparam int ZMIN = 15;
  localparam int OMIN = 35;
  localparam int MMIN = 65;
  localparam int MMAX = 95;
  localparam int PMAX = 120;

  logic       clk = 1'b0;
  logic       hrd_rst;
  logic       irig_in;
  logic [2:0] irig_data;
  logic       en;
  logic [7:0] ind;
  logic       cal;
  logic       sym_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int en_cyc = 0;
  int err_cyc = 0;
  logic [2:0] last_data = 3'b000;
  logic [7:0] last_ind = 8'd0;
  logic       last_cal = 1'b0;
  logic       last_err = 1'b0;
  int rise_cyc = 0;
  int fall_cyc = 0;

  irig_bit_decoder #(
    .CNT_W     (16),
    .ZERO_MIN  (ZMIN),
    .ONE_MIN   (OMIN),
    .MARK_MIN  (MMIN),
    .MARK_MAX  (MMAX),
    .PERIOD_MAX(PMAX)
  ) dut (
    .clk      (clk),
    .hrd_rst  (hrd_rst),
    .irig_in  (irig_in),
    .irig_data(irig_data),
    .en       (en),
    .ind      (ind),
    .cal      (cal),
    .sym_err  (sym_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe and error pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_cnt    <= en_cnt + 1;
      en_cyc    <= cyc;
      last_data <= irig_data;
      last_ind  <= ind;
      last_cal  <= cal;
      last_err  <= sym_err;
    end
    if (sym_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  // One pulse of 'width' clk high followed by the low part of a 100-clk
  // period (at least 10 clk low for long pulses).
  task automatic send_sym(input int width);
    int low;
    low = (width > 90) ? 10 : 100 - width;
    @(negedge clk);
    irig_in  = 1'b1;
    rise_cyc = cyc;
    repeat (width) @(negedge clk);
    irig_in  = 1'b0;
    fall_cyc = cyc;
    repeat (low - 1) @(negedge clk);
  endtask

  function automatic int frame_width(input int i);
    if ((i == 0) || (i % 10 == 9)) return 80;
    return (i % 2 == 1) ? 50 : 20;
  endfunction

  function automatic logic [2:0] frame_code(input int i);
    if ((i == 0) || (i % 10 == 9)) return 3'b111;
    return (i % 2 == 1) ? 3'b011 : 3'b001;
  endfunction

  task automatic send_frame(input int from, input int to);
    for (int i = from; i <= to; i++) send_sym(frame_width(i));
  endtask

  task automatic relock();
    send_sym(80);
    send_sym(80);
  endtask

  task automatic test_reset();
    hrd_rst = 1'b1;
    irig_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    hrd_rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (irig_data !== 3'b000) begin n_bad++; $display("FAIL rst_data: got %b want 000", irig_data); end
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b want 0", en); end
    n_cmp++; if (ind !== 8'd0) begin n_bad++; $display("FAIL rst_ind: got %0d want 0", ind); end
    n_cmp++; if (cal !== 1'b0) begin n_bad++; $display("FAIL rst_cal: got %b want 0", cal); end
    n_cmp++; if (sym_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", sym_err); end
  endtask

  task automatic test_nominal();
    int         w[3]   = '{20, 50, 80};
    logic [2:0] exp[3] = '{3'b001, 3'b011, 3'b111};
    int n0;
    for (int k = 0; k < 3; k++) begin
      n0 = en_cnt;
      send_sym(w[k]);
      n_cmp++; if (en_cnt !== n0 + 1) begin n_bad++; $display("FAIL nom_en_count[%0d]: got %0d want %0d", k, en_cnt - n0, 1); end
      n_cmp++; if (last_data !== exp[k]) begin n_bad++; $display("FAIL nom_data[%0d]: got %b want %b", k, last_data, exp[k]); end
      n_cmp++; if (en_cyc - fall_cyc !== 4) begin n_bad++; $display("FAIL nom_latency[%0d]: got %0d want 4", k, en_cyc - fall_cyc); end
      n_cmp++; if (last_cal !== 1'b0) begin n_bad++; $display("FAIL nom_cal[%0d]: got %b want 0", k, last_cal); end
      n_cmp++; if (last_ind !== 8'd0) begin n_bad++; $display("FAIL nom_ind[%0d]: got %0d want 0", k, last_ind); end
    end
  endtask

  // Classification thresholds on both sides; ordered so the sequence never
  // holds two adjacent markers and ends back in HUNT.
  task automatic test_boundaries();
    int         w[9]   = '{14, 15, 34, 35, 64, 65, 96, 95, 20};
    logic [2:0] exp[9] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011,
                           3'b111, 3'b000, 3'b111, 3'b001};
    for (int k = 0; k < 9; k++) begin
      send_sym(w[k]);
      n_cmp++; if (last_data !== exp[k]) begin n_bad++; $display("FAIL bnd_data[w=%0d]: got %b want %b", w[k], last_data, exp[k]); end
      n_cmp++; if (last_cal !== 1'b0) begin n_bad++; $display("FAIL bnd_cal[w=%0d]: got %b want 0", w[k], last_cal); end
    end
  endtask

  task automatic test_sync();
    int e0;
    e0 = err_cnt;
    send_sym(80);
    n_cmp++; if (last_cal !== 1'b0) begin n_bad++; $display("FAIL sync_p0_cal: got %b want 0", last_cal); end
    send_sym(80);
    n_cmp++; if (last_cal !== 1'b1) begin n_bad++; $display("FAIL sync_pr_cal: got %b want 1", last_cal); end
    n_cmp++; if (last_ind !== 8'd0) begin n_bad++; $display("FAIL sync_pr_ind: got %0d want 0", last_ind); end
    n_cmp++; if (last_data !== 3'b111) begin n_bad++; $display("FAIL sync_pr_data: got %b want 111", last_data); end
    for (int i = 1; i <= 99; i++) begin
      send_sym(frame_width(i));
      n_cmp++; if (last_ind !== 8'(i)) begin n_bad++; $display("FAIL sync_ind[%0d]: got %0d want %0d", i, last_ind, i); end
      n_cmp++; if (last_data !== frame_code(i)) begin n_bad++; $display("FAIL sync_data[%0d]: got %b want %b", i, last_data, frame_code(i)); end
      n_cmp++; if (last_cal !== 1'b1) begin n_bad++; $display("FAIL sync_cal[%0d]: got %b want 1", i, last_cal); end
    end
    send_sym(80);
    n_cmp++; if (last_ind !== 8'd0) begin n_bad++; $display("FAIL sync_wrap_ind: got %0d want 0", last_ind); end
    n_cmp++; if (last_cal !== 1'b1) begin n_bad++; $display("FAIL sync_wrap_cal: got %b want 1", last_cal); end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL sync_no_err: got %0d want 0", err_cnt - e0); end
  endtask

  // Starts locked at ind 0 (left there by test_sync).
  task automatic test_misplaced();
    int e0;
    send_frame(1, 24);
    e0 = err_cnt;
    send_sym(80);
    n_cmp++; if (last_ind !== 8'd25) begin n_bad++; $display("FAIL mis_ind: got %0d want 25", last_ind); end
    n_cmp++; if (last_data !== 3'b111) begin n_bad++; $display("FAIL mis_data: got %b want 111", last_data); end
    n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL mis_err_at_en: got %b want 1", last_err); end
    n_cmp++; if (last_cal !== 1'b0) begin n_bad++; $display("FAIL mis_cal_at_en: got %b want 0", last_cal); end
    n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL mis_err_count: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (ind !== 8'd0) begin n_bad++; $display("FAIL mis_ind_after: got %0d want 0", ind); end
    n_cmp++; if (cal !== 1'b0) begin n_bad++; $display("FAIL mis_cal_after: got %b want 0", cal); end
  endtask

  task automatic test_glitch_overlong();
    relock();
    send_sym(20);
    send_sym(10);
    n_cmp++; if (last_data !== 3'b000) begin n_bad++; $display("FAIL gl_data: got %b want 000", last_data); end
    n_cmp++; if (last_ind !== 8'd2) begin n_bad++; $display("FAIL gl_ind: got %0d want 2", last_ind); end
    n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL gl_err: got %b want 1", last_err); end
    n_cmp++; if (cal !== 1'b0) begin n_bad++; $display("FAIL gl_cal: got %b want 0", cal); end
    relock();
    send_sym(98);
    n_cmp++; if (last_data !== 3'b000) begin n_bad++; $display("FAIL ol_data: got %b want 000", last_data); end
    n_cmp++; if (last_ind !== 8'd1) begin n_bad++; $display("FAIL ol_ind: got %0d want 1", last_ind); end
    n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL ol_err: got %b want 1", last_err); end
    n_cmp++; if (cal !== 1'b0) begin n_bad++; $display("FAIL ol_cal: got %b want 0", cal); end
  endtask

  task automatic test_signal_loss();
    int e0, n0;
    relock();
    e0 = err_cnt;
    n0 = en_cnt;
    send_sym(20);              // last rise; input then stays low for 130 clk
    repeat (50) @(negedge clk);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL los_err_count: got %0d want 1", err_cnt - e0); end
    // 2 synchronizer + 1 edge stage before the period counter restarts.
    n_cmp++; if (err_cyc - rise_cyc !== PMAX + 3) begin n_bad++; $display("FAIL los_err_time: got %0d want %0d", err_cyc - rise_cyc, PMAX + 3); end
    n_cmp++; if (en_cnt !== n0 + 1) begin n_bad++; $display("FAIL los_en_count: got %0d want 1", en_cnt - n0); end
    n_cmp++; if (cal !== 1'b0) begin n_bad++; $display("FAIL los_cal: got %b want 0", cal); end
    n_cmp++; if (ind !== 8'd0) begin n_bad++; $display("FAIL los_ind: got %0d want 0", ind); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    relock();
    send_frame(1, 40);
    n_cmp++; if (last_ind !== 8'd40) begin n_bad++; $display("FAIL rm_pre_ind: got %0d want 40", last_ind); end
    @(negedge clk);
    irig_in = 1'b1;
    repeat (20) @(negedge clk);
    hrd_rst = 1'b1;
    @(negedge clk);
    hrd_rst = 1'b0;
    n0 = en_cnt;
    n_cmp++; if (irig_data !== 3'b000) begin n_bad++; $display("FAIL rm_data: got %b want 000", irig_data); end
    n_cmp++; if (ind !== 8'd0) begin n_bad++; $display("FAIL rm_ind: got %0d want 0", ind); end
    n_cmp++; if (cal !== 1'b0) begin n_bad++; $display("FAIL rm_cal: got %b want 0", cal); end
    n_cmp++; if ({en, sym_err} !== 2'b00) begin n_bad++; $display("FAIL rm_en_err: got %b want 00", {en, sym_err}); end
    repeat (30) @(negedge clk);
    irig_in = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++; if (en_cnt !== n0) begin n_bad++; $display("FAIL rm_partial: got %0d strobes want 0", en_cnt - n0); end
    send_sym(80);
    n_cmp++; if (last_cal !== 1'b0) begin n_bad++; $display("FAIL rm_m1_cal: got %b want 0", last_cal); end
    send_sym(20);
    send_sym(80);
    n_cmp++; if (last_cal !== 1'b0) begin n_bad++; $display("FAIL rm_m2_cal: got %b want 0", last_cal); end
    send_sym(80);
    n_cmp++; if (last_cal !== 1'b1) begin n_bad++; $display("FAIL rm_relock_cal: got %b want 1", last_cal); end
    n_cmp++; if (last_ind !== 8'd0) begin n_bad++; $display("FAIL rm_relock_ind: got %0d want 0", last_ind); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_sync();
    test_misplaced();
    test_glitch_overlong();
    test_signal_loss();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
